// File: rtl/booth_r8_iter_mul.sv
`default_nettype none
// ============================================================================
//  Module   : booth_r8_iter_mul
//  Brief    : Multi-cycle radix-8 Booth mantissa multiplier (FP16/BF16/INT8)
//             with valid/ready handshakes on input and output.
//  Revision : 1.0  initial release
// ============================================================================
module booth_r8_iter_mul #(
    parameter int MANT_W = 11,
    parameter int DPC    = 1,
    parameter int P_W    = 2 * MANT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        mode,
    input  logic [MANT_W-1:0] a_mant,
    input  logic [MANT_W-1:0] b_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [P_W-1:0]    product,
    output logic              out_err,
    output logic              busy
);

    localparam int c_ax_w     = MANT_W + 3;
    localparam int c_n_wide   = (MANT_W + 3) / 3;
    localparam int c_bx_w     = 3 * c_n_wide + 1;
    localparam int c_cnt_w    = $clog2(c_n_wide + DPC + 1);
    localparam logic [c_cnt_w-1:0] c_dpc      = c_cnt_w'(DPC);
    localparam logic [c_cnt_w-1:0] c_n_narrow = c_cnt_w'(3);
    localparam logic [c_cnt_w-1:0] c_n_full   = c_cnt_w'(c_n_wide);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state, w_next;

    logic [1:0]          r_mode;
    logic [MANT_W-1:0]   r_a, r_b;
    logic [c_ax_w-1:0]   r_ax, r_a3;
    logic [c_bx_w-1:0]   r_bx;
    logic [P_W-1:0]      r_acc, r_product;
    logic [c_cnt_w-1:0]  r_cnt;

    logic                w_narrow, w_signed, w_last;
    logic [c_cnt_w-1:0]  w_n;
    logic [c_ax_w-1:0]   w_a_x;
    logic [c_bx_w-1:0]   w_b_x;
    logic [P_W-1:0]      w_acc_nxt;
    logic [P_W-1:0]      w_pp  [DPC];
    logic [P_W-1:0]      w_cin [DPC];

    // Mode 11 falls through to the wide (FP16) arithmetic path.
    assign w_narrow = (r_mode == 2'b01) || (r_mode == 2'b10);
    assign w_signed = (r_mode == 2'b10);
    assign w_n      = w_narrow ? c_n_narrow : c_n_full;
    assign w_last   = (r_cnt + c_dpc) >= w_n;

    always_comb begin
        w_a_x = '0;
        w_b_x = '0;
        if (w_narrow) begin
            w_a_x[7:0] = r_a[7:0];
            w_b_x[8:1] = r_b[7:0];
            if (w_signed) begin
                w_a_x[c_ax_w-1:8] = {(c_ax_w - 8){r_a[7]}};
                w_b_x[c_bx_w-1:9] = {(c_bx_w - 9){r_b[7]}};
            end
        end else begin
            w_a_x[MANT_W-1:0] = r_a;
            w_b_x[MANT_W:1]   = r_b;
        end
    end

    function automatic logic [c_ax_w-1:0] f_mag_mult(
        input logic [3:0]        dig,
        input logic [c_ax_w-1:0] ax,
        input logic [c_ax_w-1:0] a3
    );
        case (dig)
            4'b0001, 4'b0010, 4'b1101, 4'b1110: f_mag_mult = ax;
            4'b0011, 4'b0100, 4'b1011, 4'b1100: f_mag_mult = ax << 1;
            4'b0101, 4'b0110, 4'b1001, 4'b1010: f_mag_mult = a3;
            4'b0111, 4'b1000:                   f_mag_mult = ax << 2;
            default:                            f_mag_mult = '0;
        endcase
    endfunction

    // Slot k always reads the low bits of the shifting B register; a slot
    // past the last digit is forced to a zero digit.
    generate
        for (genvar k = 0; k < DPC; k++) begin : g_slot
            logic                w_act;
            logic [3:0]          w_dig;
            logic [c_ax_w-1:0]   w_mag;
            logic [P_W-1:0]      w_ext;
            logic [7:0]          w_sh;

            assign w_act    = (r_cnt + c_cnt_w'(k)) < w_n;
            assign w_dig    = w_act ? r_bx[3*k +: 4] : 4'b0000;
            assign w_mag    = f_mag_mult(w_dig, r_ax, r_a3);
            assign w_ext    = {{(P_W - c_ax_w){w_mag[c_ax_w-1]}}, w_mag};
            assign w_sh     = 8'(3 * (int'(r_cnt) + k));
            assign w_pp[k]  = (w_dig[3] ? ~w_ext : w_ext) << w_sh;
            assign w_cin[k] = P_W'(w_dig[3]) << w_sh;
        end
    endgenerate

    always_comb begin
        w_acc_nxt = r_acc;
        for (int k = 0; k < DPC; k++) begin
            w_acc_nxt = w_acc_nxt + w_pp[k] + w_cin[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_err   = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_next = S_PRE;
            end
            S_PRE:  w_next = S_ITER;
            S_ITER: if (w_last) w_next = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                out_err   = (r_mode == 2'b11);
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode    <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_ax      <= '0;
            r_a3      <= '0;
            r_bx      <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mode <= mode;
                        r_a    <= a_mant;
                        r_b    <= b_mant;
                    end
                end
                S_PRE: begin
                    r_ax  <= w_a_x;
                    r_a3  <= w_a_x + (w_a_x << 1);
                    r_bx  <= w_b_x;
                    r_acc <= '0;
                    r_cnt <= '0;
                end
                S_ITER: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + c_dpc;
                    r_bx  <= $signed(r_bx) >>> (3 * DPC);
                    if (w_last) r_product <= w_acc_nxt;
                end
                default: ;
            endcase
        end
    end

    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_booth_r8_iter_mul.sv
`default_nettype none
// ============================================================================
//  Module   : tb_booth_r8_iter_mul
//  Brief    : Scoreboard bench for booth_r8_iter_mul, DPC=1 and DPC=2 builds.
//  Revision : 1.0  initial release
// ============================================================================
module tb_booth_r8_iter_mul;

    localparam int MW = 11;
    localparam int PW = 2 * MW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [1:0]    in_valid, in_ready, out_valid, out_ready, out_err, busy;
    logic [1:0]    mode    [2];
    logic [MW-1:0] a_mant  [2];
    logic [MW-1:0] b_mant  [2];
    logic [PW-1:0] product [2];

    booth_r8_iter_mul #(.MANT_W(MW), .DPC(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .mode(mode[0]),
        .a_mant(a_mant[0]), .b_mant(b_mant[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .product(product[0]), .out_err(out_err[0]), .busy(busy[0])
    );

    booth_r8_iter_mul #(.MANT_W(MW), .DPC(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .mode(mode[1]),
        .a_mant(a_mant[1]), .b_mant(b_mant[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .product(product[1]), .out_err(out_err[1]), .busy(busy[1])
    );

    typedef struct {
        logic [PW-1:0] p;
        logic          e;
        int            lat;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   t_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [PW-1:0] ref_mul(input logic [1:0] m,
                                              input logic [MW-1:0] a,
                                              input logic [MW-1:0] b);
        longint pa, pb, r;
        if (m == 2'b10) begin
            pa = $signed(a[7:0]);
            pb = $signed(b[7:0]);
        end else if (m == 2'b01) begin
            pa = longint'(a[7:0]);
            pb = longint'(b[7:0]);
        end else begin
            pa = longint'(a);
            pb = longint'(b);
        end
        r = pa * pb;
        return r[PW-1:0];
    endfunction

    function automatic int ref_lat(input logic [1:0] m, input int dpc);
        int n;
        n = (m == 2'b01 || m == 2'b10) ? 3 : 4;
        return 1 + (n + dpc - 1) / dpc;
    endfunction

    task automatic send(input int sel, input logic [1:0] m,
                        input logic [MW-1:0] a, input logic [MW-1:0] b,
                        input int dpc);
        exp_t x;
        int   guard = 0;
        @(negedge clk);
        while (in_ready[sel] !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout sel=%0d in_ready=%b required 1", sel, in_ready[sel]);
        end
        in_valid[sel] = 1'b1;
        mode[sel]     = m;
        a_mant[sel]   = a;
        b_mant[sel]   = b;
        x.p   = ref_mul(m, a, b);
        x.e   = (m == 2'b11);
        x.lat = ref_lat(m, dpc);
        q.push_back(x);
        @(posedge clk);
        #1;
        t_acc         = cyc;
        in_valid[sel] = 1'b0;
        mode[sel]     = 2'($urandom);
        a_mant[sel]   = MW'($urandom);
        b_mant[sel]   = MW'($urandom);
    endtask

    task automatic recv(input int sel, output logic [PW-1:0] p, output logic e,
                        output int lat, output bit ok);
        int guard = 0;
        ok  = 1'b0;
        p   = 'x;
        e   = 1'bx;
        lat = -1;
        @(negedge clk);
        while (out_valid[sel] !== 1'b1 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (out_valid[sel] === 1'b1) begin
            ok  = 1'b1;
            p   = product[sel];
            e   = out_err[sel];
            lat = cyc - t_acc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++; if (in_ready[0] !== 1'b1)  begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready[0]); end
        n_vec++; if (out_valid[0] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid[0]); end
        n_vec++; if (product[0] !== '0)     begin n_bad++; $display("FAIL reset_product got %h want 0", product[0]); end
        n_vec++; if (out_err[0] !== 1'b0)   begin n_bad++; $display("FAIL reset_out_err got %b want 0", out_err[0]); end
        n_vec++; if (busy[0] !== 1'b0)      begin n_bad++; $display("FAIL reset_busy got %b want 0", busy[0]); end
    endtask

    task automatic test_fp16_max();
        logic [PW-1:0] p; logic e; int lat; bit ok; exp_t x;
        send(0, 2'b00, 11'h7FF, 11'h7FF, 1);
        recv(0, p, e, lat, ok);
        x = q.pop_front();
        n_vec++; if (!ok || p !== x.p) begin n_bad++; $display("FAIL fp16_max_product got %h want %h", p, x.p); end
        n_vec++; if (e !== x.e)        begin n_bad++; $display("FAIL fp16_max_err got %b want %b", e, x.e); end
        n_vec++; if (lat != x.lat)     begin n_bad++; $display("FAIL fp16_max_latency got %0d want %0d", lat, x.lat); end
    endtask

    task automatic test_int8_extremes();
        logic [PW-1:0] p; logic e; int lat; bit ok; exp_t x;
        logic [MW-1:0] bv [2];
        bv[0] = 11'h080;
        bv[1] = 11'h07F;
        for (int i = 0; i < 2; i++) begin
            send(0, 2'b10, 11'h080, bv[i], 1);
            recv(0, p, e, lat, ok);
            x = q.pop_front();
            n_vec++; if (!ok || p !== x.p) begin n_bad++; $display("FAIL int8_product[%0d] got %h want %h", i, p, x.p); end
            n_vec++; if (lat != x.lat || e !== 1'b0) begin n_bad++; $display("FAIL int8_lat_err[%0d] got %0d/%b want %0d/0", i, lat, e, x.lat); end
        end
    endtask

    task automatic test_bf16_backpressure();
        exp_t x;
        int   guard = 0;
        int   lat;
        out_ready[0] = 1'b0;
        send(0, 2'b01, 11'h080, 11'h0FF, 1);
        x = q.pop_front();
        @(negedge clk);
        while (out_valid[0] !== 1'b1 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        lat = cyc - t_acc;
        n_vec++; if (out_valid[0] !== 1'b1 || lat != x.lat) begin n_bad++; $display("FAIL bf16_bp_latency got %0d want %0d", lat, x.lat); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid[0] !== 1'b1 || product[0] !== x.p || in_ready[0] !== 1'b0 || out_err[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL bf16_bp_hold[%0d] valid=%b product=%h in_ready=%b err=%b want 1/%h/0/0",
                         i, out_valid[0], product[0], in_ready[0], out_err[0], x.p);
            end
        end
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0 || out_valid[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL bf16_bp_idle in_ready=%b busy=%b valid=%b want 1/0/0", in_ready[0], busy[0], out_valid[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [PW-1:0] p; logic e; int lat; bit ok; exp_t x;
        send(0, 2'b00, 11'h5A5, 11'h3C3, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        n_vec++;
        if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0 || out_valid[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_state in_ready=%b busy=%b valid=%b want 1/0/0", in_ready[0], busy[0], out_valid[0]);
        end
        send(0, 2'b00, 11'd3, 11'd5, 1);
        recv(0, p, e, lat, ok);
        x = q.pop_front();
        n_vec++; if (!ok || p !== x.p || lat != x.lat) begin n_bad++; $display("FAIL rst_mid_followup got %h lat %0d want %h lat %0d", p, lat, x.p, x.lat); end
    endtask

    task automatic test_illegal_mode();
        logic [PW-1:0] p; logic e; int lat; bit ok; exp_t x;
        send(0, 2'b11, 11'h400, 11'h002, 1);
        recv(0, p, e, lat, ok);
        x = q.pop_front();
        n_vec++; if (!ok || p !== x.p) begin n_bad++; $display("FAIL illegal_product got %h want %h", p, x.p); end
        n_vec++; if (e !== x.e)        begin n_bad++; $display("FAIL illegal_err got %b want %b", e, x.e); end
        @(negedge clk);
        n_vec++; if (out_err[0] !== 1'b0) begin n_bad++; $display("FAIL illegal_err_clear got %b want 0", out_err[0]); end
    endtask

    task automatic test_back_to_back(input int sel, input int dpc, input int nops);
        logic [PW-1:0] p; logic e; int lat; bit ok; exp_t x;
        for (int i = 0; i < nops; i++) begin
            send(sel, 2'($urandom), MW'($urandom), MW'($urandom), dpc);
            recv(sel, p, e, lat, ok);
            x = q.pop_front();
            n_vec++;
            if (!ok || p !== x.p || e !== x.e || lat != x.lat) begin
                n_bad++;
                $display("FAIL b2b_dpc%0d[%0d] got %h/%b/%0d want %h/%b/%0d", dpc, i, p, e, lat, x.p, x.e, x.lat);
            end
        end
    endtask

    task automatic test_dpc2();
        logic [PW-1:0] p; logic e; int lat; bit ok; exp_t x;
        send(1, 2'b00, 11'h7FF, 11'h001, 2);
        recv(1, p, e, lat, ok);
        x = q.pop_front();
        n_vec++; if (!ok || p !== x.p) begin n_bad++; $display("FAIL dpc2_product got %h want %h", p, x.p); end
        n_vec++; if (lat != x.lat)     begin n_bad++; $display("FAIL dpc2_latency got %0d want %0d", lat, x.lat); end
        test_back_to_back(1, 2, 16);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 2'b11;
        for (int i = 0; i < 2; i++) begin
            mode[i]   = '0;
            a_mant[i] = '0;
            b_mant[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_fp16_max();
        test_int8_extremes();
        test_bf16_backpressure();
        test_reset_mid();
        test_illegal_mode();
        test_back_to_back(0, 1, 16);
        test_dpc2();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
